// File: rtl/csa8_add_sched_pkg.sv
// Shared definitions for the byte-serial shared-adder scheduler:
// FSM encoding, slice width and requester IDs.
package csa8_add_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 8;

  localparam logic ID_PC  = 1'b0;
  localparam logic ID_ALU = 1'b1;

endpackage

// File: rtl/csa8_add_sched_nov.sv
// 8-bit carry-select adder slice: the low nibble ripples, the high nibble
// is precomputed for both carries and selected by the low-nibble carry.
module csa8_nov
  import csa8_add_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               carry_out
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
  assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;

  assign sum       = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign carry_out = lo[4] ? hi1[4] : hi0[4];

endmodule

// File: rtl/csa8_add_sched.sv
// Round-robin scheduler sharing one 8-bit carry-select slice between two
// requesters; a WIDTH-bit add is sequenced LSB byte first with a carry register.
module csa8_add_sched
  import csa8_add_sched_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  localparam int SLICES = WIDTH / SLICE_W;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               id_q, id_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               grant0, grant1;
  logic [SLICE_W-1:0] a_byte, b_byte, s_byte;
  logic               c_slice;

  function automatic logic ovf_f(input logic a_msb, input logic b_msb,
                                 input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // Port 0 wins unless port 1 also asks and port 0 was served last.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || (last_grant_q == ID_ALU));
    grant1     = req1_valid && !grant0;
    req0_ready = !rst && (state_q == ST_IDLE) && grant0;
    req1_ready = !rst && (state_q == ST_IDLE) && grant1;
  end

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < SLICES; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_byte = a_q[k*SLICE_W +: SLICE_W];
        b_byte = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  csa8_nov u_slice (
    .a         (a_byte),
    .b         (b_byte),
    .cin       (carry_q),
    .sum       (s_byte),
    .carry_out (c_slice)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    sum_d        = sum_q;
    cout_d       = cout_q;
    ovf_d        = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          id_d         = req1_ready ? ID_ALU : ID_PC;
          a_d          = req1_ready ? req1_a   : req0_a;
          b_d          = req1_ready ? req1_b   : req0_b;
          carry_d      = req1_ready ? req1_cin : req0_cin;
          cnt_d        = '0;
          last_grant_d = id_d;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < SLICES; k++) begin
          if (cnt_q == CNT_W'(k)) sum_d[k*SLICE_W +: SLICE_W] = s_byte;
        end
        carry_d = c_slice;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          cout_d  = c_slice;
          ovf_d   = ovf_f(a_q[WIDTH-1], b_q[WIDTH-1], s_byte[SLICE_W-1]);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= ID_ALU;
      id_q         <= 1'b0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      sum_q        <= sum_d;
      cout_q       <= cout_d;
      ovf_q        <= ovf_d;
    end
  end

  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_csa8_add_sched.sv
// Directed bench for csa8_add_sched: a round-robin grant model and a
// whole-word addition scoreboard check every accepted operation.
module tb_csa8_add_sched;

  localparam int WIDTH  = 32;
  localparam int SLICES = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_cin;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [WIDTH-1:0] rsp_sum;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               cyc;
  } want_t;

  want_t sb[$];

  int   n_checks = 0;
  int   n_err    = 0;
  int   n_acc    = 0;
  int   n_rsp    = 0;
  int   cyc      = 0;
  int   first_cyc = 0;
  int   last_acc_cyc = 0;
  logic prev_valid = 1'b0;
  logic model_last = 1'b1;
  logic fair_mode  = 1'b0;
  logic fair_first = 1'b0;
  logic [WIDTH-1:0] last_sum;

  always #5 clk = ~clk;

  csa8_add_sched #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_ovf    (rsp_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Sample mid-cycle, record handshakes, then advance one clock.
  task automatic step();
    logic acc0, acc1, p, want_p;
    logic [WIDTH:0] full;
    logic [WIDTH-1:0] oa, ob;
    want_t e;
    #1;
    if (rst) begin
      sb.delete();
      model_last = 1'b1;
    end
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (acc0 || acc1) begin
      chk("single_ready", {63'd0, acc0 && acc1}, 64'd0);
      p = acc1;
      want_p = (req0_valid && req1_valid) ? ~model_last : (req0_valid ? 1'b0 : 1'b1);
      chk("grant_port", {63'd0, p}, {63'd0, want_p});
      model_last = p;
      if (fair_mode && !fair_first) chk("grant_spacing", 64'(cyc - last_acc_cyc), 64'(SLICES + 2));
      fair_first = 1'b0;
      oa = p ? req1_a : req0_a;
      ob = p ? req1_b : req0_b;
      full = {1'b0, oa} + {1'b0, ob} + {{WIDTH{1'b0}}, (p ? req1_cin : req0_cin)};
      e.id   = p;
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (oa[WIDTH-1] == ob[WIDTH-1]) && (full[WIDTH-1] != oa[WIDTH-1]);
      e.cyc  = cyc;
      sb.push_back(e);
      last_acc_cyc = cyc;
      n_acc++;
    end
    if (rsp_valid && !prev_valid) first_cyc = cyc;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id",   {63'd0, rsp_id},   {63'd0, e.id});
        chk("rsp_sum",  {32'd0, rsp_sum},  {32'd0, e.sum});
        chk("rsp_cout", {63'd0, rsp_cout}, {63'd0, e.cout});
        chk("rsp_ovf",  {63'd0, rsp_ovf},  {63'd0, e.ovf});
        chk("latency",  64'(first_cyc - e.cyc), 64'(SLICES + 1));
      end
      last_sum = rsp_sum;
      n_rsp++;
    end
    prev_valid = rsp_valid;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_rsp();
    int tgt = n_rsp + 1;
    int i = 0;
    while (n_rsp < tgt && i < 40) begin
      step();
      i++;
    end
    if (n_rsp < tgt) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic p, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin);
    int tgt = n_acc + 1;
    int i = 0;
    if (p) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    while (n_acc < tgt && i < 20) begin
      step();
      i++;
    end
    if (n_acc < tgt) chk("accept_timeout", 64'd0, 64'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1);
  end

  initial begin
    int acc_start;
    int i;
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h0000_0001; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h0000_0005; req1_b = 32'h0000_0006; req1_cin = 1'b0;
    @(posedge clk);
    #1;

    // Reset with both requesters asking
    repeat (3) begin
      step();
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
      chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
    end
    rst = 1'b0;
    #1;
    chk("first_ready0", {63'd0, req0_ready}, 64'd1);
    chk("first_ready1", {63'd0, req1_ready}, 64'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp();
    chk("ripple_sum", {32'd0, last_sum}, 64'h100);

    // Corner arithmetic
    run_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("ovf_pos_sum", {32'd0, last_sum}, 64'h8000_0000);
    run_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    chk("cin_wrap_sum", {32'd0, last_sum}, 64'h0);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'hEDCB_A988, 1'b1);

    // Fairness with both requesters continuously valid
    req0_valid = 1'b1; req0_a = 32'h0000_0001; req0_b = 32'h0000_0002; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h00FF_0003; req1_b = 32'h0001_0004; req1_cin = 1'b1;
    fair_mode = 1'b1;
    fair_first = 1'b1;
    acc_start = n_acc;
    repeat (36) step();
    fair_mode = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("fair_grants", {63'd0, (n_acc - acc_start) >= 6}, 64'd1);
    i = 0;
    while (sb.size() > 0 && i < 40) begin
      step();
      i++;
    end
    chk("fair_drain", 64'(sb.size()), 64'd0);

    // Backpressure in DONE
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h1111_1111; req1_cin = 1'b0;
    acc_start = n_acc;
    i = 0;
    while (n_acc == acc_start && i < 20) begin
      step();
      i++;
    end
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_000F; req0_b = 32'h0000_0001; req0_cin = 1'b0;
    i = 0;
    while (!rsp_valid && i < 20) begin
      step();
      i++;
    end
    repeat (10) begin
      step();
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_sum",   {32'd0, rsp_sum}, 64'h2345_6789);
      chk("bp_id",    {63'd0, rsp_id}, 64'd1);
      chk("bp_cout",  {62'd0, rsp_cout, rsp_ovf}, 64'd0);
      chk("bp_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_idle_valid", {63'd0, rsp_valid}, 64'd0);
    chk("bp_new_grant", {63'd0, req0_ready}, 64'd1);
    step();
    req0_valid = 1'b0;
    wait_rsp();
    chk("bp_next_sum", {32'd0, last_sum}, 64'h10);

    // Reset while the counter is at slice 2
    req0_valid = 1'b1; req0_a = 32'hAAAA_5555; req0_b = 32'h5555_AAAB; req0_cin = 1'b1;
    acc_start = n_acc;
    i = 0;
    while (n_acc == acc_start && i < 20) begin
      step();
      i++;
    end
    req0_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midrst_sum", {32'd0, rsp_sum}, 64'd0);
    acc_start = n_rsp;
    repeat (8) step();
    chk("midrst_no_rsp", 64'(n_rsp - acc_start), 64'd0);
    run_op(1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0);
    chk("midrst_after_sum", {32'd0, last_sum}, 64'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
